// File: rtl/upd78xx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : upd78xx_pkg
// Purpose  : Shared types and constants for the uPD78xx microcode sequencer
//            (branch-mode encoding, default fetch vector, sizing helpers).
// Revision : 1.0  initial release
// ============================================================================
package upd78xx_pkg;

   // Branch mode carried in each microword
   typedef enum logic [2:0] {
      BM_ADV   = 3'd0,   // sequential advance
      BM_DA    = 3'd1,   // direct address from NUA
      BM_AT    = 3'd2,   // opcode dispatch address
      BM_CJ    = 3'd3,   // conditional jump to NUA
      BM_CALL  = 3'd4,   // push return address, jump to NUA
      BM_RET   = 3'd5,   // pop return address
      BM_HOLD  = 3'd6,   // stay on current microword
      BM_FETCH = 3'd7    // back to opcode fetch entry
   } e_ubm;

   // Default microcode address width and opcode-fetch entry point
   localparam int UADDR_W_DEFAULT  = 6;
   localparam int FETCH_UA_DEFAULT = 0;

   // Microcode address type for the default-width core
   typedef logic [UADDR_W_DEFAULT-1:0] e_uaddr;

   // Width of a counter able to hold 0..depth
   function automatic int f_sp_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage : upd78xx_pkg
`default_nettype wire

// File: rtl/upd78xx_ustack.sv
`default_nettype none
// ============================================================================
// Module   : upd78xx_ustack
// Purpose  : Parametrised LIFO holding microcode return addresses. Entry
//            o_sp-1 is the top; a push writes entry o_sp. Pushes when full
//            and pops when empty are ignored (the caller flags the error).
// Revision : 1.0  initial release
// ============================================================================
module upd78xx_ustack
   import upd78xx_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 6
)(
   input  logic                         CLK,
   input  logic                         RESETB,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic                         i_flush,
   input  logic [W-1:0]                 i_data,
   output logic [W-1:0]                 o_top,
   output logic [$clog2(DEPTH+1)-1:0]   o_sp,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int SPW   = f_sp_w(DEPTH);
   // Storage is rounded up to a power of two so the slot index is exactly
   // IDXW bits wide; the extra slots are never addressed.
   localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NSLOT = 1 << IDXW;

   logic [SPW-1:0]  r_sp;
   logic [W-1:0]    r_mem [NSLOT];
   logic [IDXW-1:0] w_wr_idx;
   logic [IDXW-1:0] w_rd_idx;
   logic            w_do_push;
   logic            w_do_pop;

   // Slot addressing and guarded push/pop qualifiers
   always_comb begin
      w_wr_idx  = IDXW'(r_sp);
      w_rd_idx  = IDXW'(r_sp - SPW'(1));
      o_full    = (r_sp == SPW'(DEPTH));
      o_empty   = (r_sp == '0);
      w_do_push = i_push & ~o_full & ~i_flush;
      w_do_pop  = i_pop & ~o_empty & ~i_flush;
   end

   // Occupancy counter; flush empties the stack in one cycle
   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         r_sp <= '0;
      end else if (i_flush) begin
         r_sp <= '0;
      end else if (w_do_push) begin
         r_sp <= r_sp + SPW'(1);
      end else if (w_do_pop) begin
         r_sp <= r_sp - SPW'(1);
      end
   end

   // Return-address storage; contents are don't-care after reset
   always_ff @(posedge CLK) begin
      if (w_do_push) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end

   assign o_top = r_mem[w_rd_idx];
   assign o_sp  = r_sp;

endmodule : upd78xx_ustack
`default_nettype wire

// File: rtl/upd78xx_useq.sv
`default_nettype none
// ============================================================================
// Module   : upd78xx_useq
// Purpose  : Microcode sequencer for the uPD78xx core. Produces the next
//            microcode address (advance, direct, dispatch, conditional jump,
//            call/return, hold, fetch) with wait stalling, abort re-vectoring
//            and sticky stack overflow/underflow flags.
// Revision : 1.0  initial release
// ============================================================================
module upd78xx_useq
   import upd78xx_pkg::*;
#(
   parameter int UADDR_W     = UADDR_W_DEFAULT,
   parameter int STACK_DEPTH = 2,
   parameter int NCOND       = 8,
   parameter int FETCH_UA    = FETCH_UA_DEFAULT
)(
   input  logic                               CLK,
   input  logic                               RESETB,
   input  logic                               CP2_POSEDGE,
   input  logic                               WAIT,
   input  logic                               ABORT,
   input  logic [2:0]                         BM,
   input  logic [UADDR_W-1:0]                 NUA,
   input  logic [UADDR_W-1:0]                 AT,
   input  logic [NCOND-1:0]                   COND,
   input  logic [$clog2(NCOND)-1:0]           CSEL,
   input  logic                               CPOL,
   output logic [UADDR_W-1:0]                 UPTR,
   output logic [UADDR_W-1:0]                 UPTR_NEXT,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   SP,
   output logic                               ERR_OVF,
   output logic                               ERR_UNF,
   input  logic                               ERR_CLR
);

   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int CSW = $clog2(NCOND);
   // Condition vector padded to the full CSEL range: selects at or beyond
   // NCOND land on zero-filled bits and therefore read as 0.
   localparam int NCP = 1 << CSW;
   localparam logic [UADDR_W-1:0] c_fetch = UADDR_W'(FETCH_UA);

   logic [UADDR_W-1:0] r_uptr;
   logic               r_ovf;
   logic               r_unf;

   e_ubm               w_bm;
   logic [UADDR_W-1:0] w_inc;
   logic [UADDR_W-1:0] w_next;
   logic [NCP-1:0]     w_cond_pad;
   logic               w_cond;
   logic               w_cj_taken;
   logic               w_push;
   logic               w_pop;
   logic               w_set_ovf;
   logic               w_set_unf;
   logic               w_advance;
   logic               w_stk_push;
   logic               w_stk_pop;
   logic               w_stk_flush;
   logic [UADDR_W-1:0] w_top;
   logic [SPW-1:0]     w_sp;
   logic               w_full;
   logic               w_empty;

   // Branch decode helpers: increment wraps silently, condition selection
   always_comb begin
      w_bm       = e_ubm'(BM);
      w_inc      = r_uptr + UADDR_W'(1);
      w_cond_pad = NCP'(COND);
      w_cond     = w_cond_pad[CSEL];
      w_cj_taken = (w_cond == CPOL);
   end

   // Next-address selection and stack/error requests for the current microword
   always_comb begin
      w_next    = r_uptr;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_set_ovf = 1'b0;
      w_set_unf = 1'b0;
      if (ABORT) begin
         w_next = c_fetch;
      end else if (!WAIT) begin
         case (w_bm)
            BM_ADV:   w_next = w_inc;
            BM_DA:    w_next = NUA;
            BM_AT:    w_next = AT;
            BM_CJ:    w_next = w_cj_taken ? NUA : w_inc;
            BM_CALL: begin
               // A full stack still takes the jump; only the return is lost
               w_next = NUA;
               if (w_full) begin
                  w_set_ovf = 1'b1;
               end else begin
                  w_push = 1'b1;
               end
            end
            BM_RET: begin
               // Returning with nothing stacked falls back to opcode fetch
               if (w_empty) begin
                  w_next    = c_fetch;
                  w_set_unf = 1'b1;
               end else begin
                  w_next = w_top;
                  w_pop  = 1'b1;
               end
            end
            BM_HOLD:  w_next = r_uptr;
            BM_FETCH: w_next = c_fetch;
            default:  w_next = c_fetch;
         endcase
      end
   end

   // Stack operations only take effect on an advance strobe
   always_comb begin
      w_advance   = CP2_POSEDGE & ~ABORT & ~WAIT;
      w_stk_push  = CP2_POSEDGE & w_push;
      w_stk_pop   = CP2_POSEDGE & w_pop;
      w_stk_flush = CP2_POSEDGE & ABORT;
   end

   upd78xx_ustack #(
      .DEPTH (STACK_DEPTH),
      .W     (UADDR_W)
   ) u_stack (
      .CLK     (CLK),
      .RESETB  (RESETB),
      .i_push  (w_stk_push),
      .i_pop   (w_stk_pop),
      .i_flush (w_stk_flush),
      .i_data  (w_inc),
      .o_top   (w_top),
      .o_sp    (w_sp),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Microcode address register; abort/wait are already folded into w_next
   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         r_uptr <= c_fetch;
      end else if (CP2_POSEDGE) begin
         r_uptr <= w_next;
      end
   end

   // Sticky error flags; a new error on the clearing strobe keeps the flag set
   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (w_advance) begin
         r_ovf <= w_set_ovf | (r_ovf & ~ERR_CLR);
         r_unf <= w_set_unf | (r_unf & ~ERR_CLR);
      end
   end

   assign UPTR      = r_uptr;
   assign UPTR_NEXT = w_next;
   assign SP        = w_sp;
   assign ERR_OVF   = r_ovf;
   assign ERR_UNF   = r_unf;

endmodule : upd78xx_useq
`default_nettype wire
